// File: rtl/joy_db15_scan.sv
// Two-player DB15 poller: drives a chained 74HC165 adapter, captures 32 bits per frame, and publishes debounced active-high button words.
// Latency: one frame is (GAP_TICKS + 1 + 64) ticks plus alignment and 1 clk. An update needs two identical consecutive frames.
// Backpressure: none. Results are published with a one-clk frame_valid strobe, and the consumer must sample it in that clk.
//
// Ports:
//   clk         joystick clock (40-50 MHz)
//   reset_n     asynchronous reset, active-low
//   ena         polling enable; only looked at while idle between frames
//   JOY_DATA    serial data from the '165 chain (Q7); buttons are active-low
//   JOY_CLK     shift clock to the chain; the chain advances on its rising edge
//   JOY_LOAD    parallel load to the chain, active-low
//   joystick1   player 1 buttons (raw bits 15:0), 1 = pressed
//   joystick2   player 2 buttons (raw bits 31:16), 1 = pressed
//   frame_valid one-clk pulse in the clk where joystick1/joystick2 take new values
module joy_db15_scan #(
  parameter int CLK_DIV   = 24,
  parameter int GAP_TICKS = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ena,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_valid
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_CMP
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic [GAP_W-1:0] gap_q, gap_nxt;
  logic [4:0]       bit_q, bit_nxt;
  logic             phase_q, phase_nxt;   // 0: JOY_CLK low half, 1: JOY_CLK high half
  logic [31:0]      shreg;
  logic [31:0]      prev_raw;
  logic             cap_en;
  logic             publish;
  logic             clear_out;

  // Free-running tick divider; it is never re-aligned, so frame starts
  // land on whatever tick comes next after the gap expires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_q;
    bit_nxt   = bit_q;
    phase_nxt = phase_q;
    cap_en    = 1'b0;
    publish   = 1'b0;
    clear_out = 1'b0;
    case (state)
      S_IDLE: begin
        if (!ena) begin
          gap_nxt   = '0;
          clear_out = 1'b1;
        end else if (tick) begin
          if (gap_q == GAP_LAST) begin
            gap_nxt   = '0;
            state_nxt = S_LOAD;
          end else begin
            gap_nxt = gap_q + GAP_W'(1);
          end
        end
      end
      S_LOAD: begin
        if (tick) begin
          state_nxt = S_SHIFT;
          bit_nxt   = 5'd0;
          phase_nxt = 1'b0;
        end
      end
      S_SHIFT: begin
        if (tick) begin
          if (!phase_q) begin
            // The data bit has been stable for the whole low half.
            cap_en    = 1'b1;
            phase_nxt = 1'b1;
          end else begin
            phase_nxt = 1'b0;
            if (bit_q == 5'd31) begin
              state_nxt = S_CMP;
            end else begin
              bit_nxt = bit_q + 5'd1;
            end
          end
        end
      end
      S_CMP: begin
        // Glitch filter: publish only when two consecutive frames agree.
        publish   = (shreg == prev_raw);
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      gap_q   <= '0;
      bit_q   <= 5'd0;
      phase_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      gap_q   <= gap_nxt;
      bit_q   <= bit_nxt;
      phase_q <= phase_nxt;
    end
  end

  // Pin drivers are registered from the next-state decode. They change in the
  // same clk as the state, and nothing on an input reaches a pin combinationally.
  // JOY_CLK is only high inside SHIFT, so it can never overlap JOY_LOAD low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      JOY_LOAD <= 1'b1;
      JOY_CLK  <= 1'b0;
    end else begin
      JOY_LOAD <= (state_nxt != S_LOAD);
      JOY_CLK  <= (state_nxt == S_SHIFT) && phase_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg    <= '0;
      prev_raw <= 32'hFFFF_FFFF;
    end else begin
      if (cap_en) begin
        shreg[bit_q] <= JOY_DATA;
      end
      if (state == S_CMP) begin
        prev_raw <= shreg;
      end
    end
  end

  // frame_valid is registered together with the button words, so the strobe
  // and the new values appear in the same clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      joystick1   <= 16'h0000;
      joystick2   <= 16'h0000;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= publish;
      if (publish) begin
        joystick1 <= ~shreg[15:0];
        joystick2 <= ~shreg[31:16];
      end else if (clear_out) begin
        joystick1 <= 16'h0000;
        joystick2 <= 16'h0000;
      end
    end
  end

endmodule

// File: tb/tb_joy_db15_scan.sv
module tb_joy_db15_scan;

  localparam int CLK_DIV   = 2;
  localparam int GAP_TICKS = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        ena = 1'b0;
  logic        JOY_DATA;
  logic        JOY_CLK;
  logic        JOY_LOAD;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        frame_valid;

  int checks = 0;
  int failures = 0;

  joy_db15_scan #(
    .CLK_DIV  (CLK_DIV),
    .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ena        (ena),
    .JOY_DATA   (JOY_DATA),
    .JOY_CLK    (JOY_CLK),
    .JOY_LOAD   (JOY_LOAD),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  // Model of the '165 chain: async parallel load while JOY_LOAD is low, and a shift
  // toward Q7 on each JOY_CLK rise. Bit 0 of the pattern is the first bit out.
  logic [31:0] chain_pat = 32'hFFFF_FFFF;
  logic [31:0] sr = 32'hFFFF_FFFF;
  logic        disc = 1'b0;

  always @(negedge JOY_LOAD or posedge JOY_CLK) begin
    if (!JOY_LOAD) sr <= chain_pat;
    else           sr <= {1'b1, sr[31:1]};
  end

  assign JOY_DATA = disc ? 1'b1 : sr[0];

  // Pin and strobe monitor, sampled on the inactive edge.
  int          cyc = 0;
  int          fv_cnt = 0;
  int          rise_cnt = 0;
  int          load_cnt = 0;
  int          spacing_bad = 0;
  int          edge_in_load = 0;
  int          last_rise = 0;
  int          cur_load_len = 0;
  int          last_load_len = 0;
  bit          first_rise = 1'b1;
  logic        jclk_p = 1'b0;
  logic        jload_p = 1'b1;
  logic [15:0] fv_j1 = 16'h0;
  logic [15:0] fv_j2 = 16'h0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (frame_valid) begin
      fv_cnt <= fv_cnt + 1;
      fv_j1  <= joystick1;
      fv_j2  <= joystick2;
    end
    if (!JOY_LOAD) cur_load_len <= cur_load_len + 1;
    if (!JOY_LOAD && jload_p) begin
      load_cnt   <= load_cnt + 1;
      first_rise <= 1'b1;
    end
    if (JOY_LOAD && !jload_p) begin
      last_load_len <= cur_load_len;
      cur_load_len  <= 0;
    end
    if (!JOY_LOAD && (JOY_CLK || JOY_CLK !== jclk_p)) edge_in_load <= edge_in_load + 1;
    if (JOY_CLK && !jclk_p) begin
      rise_cnt <= rise_cnt + 1;
      if (!first_rise && (cyc - last_rise) != 2 * CLK_DIV) spacing_bad <= spacing_bad + 1;
      first_rise <= 1'b0;
      last_rise  <= cyc;
    end
    jclk_p  <= JOY_CLK;
    jload_p <= JOY_LOAD;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full frame: load the pattern, wait for the load and 32 shift clocks, and
  // return a few clks after CMP, still in the idle gap. drop_at >= 0 deasserts
  // ena after that many JOY_CLK rises.
  task automatic run_frame(input logic [31:0] pat, input int drop_at,
                           output int load_wait, output int rises, output int fvs);
    int r0;
    int f0;
    chain_pat = pat;
    f0 = fv_cnt;
    load_wait = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (!JOY_LOAD) begin
        load_wait = i;
        break;
      end
    end
    r0 = rise_cnt;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (drop_at >= 0 && rise_cnt - r0 >= drop_at) ena = 1'b0;
      if (rise_cnt - r0 >= 32) break;
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!JOY_CLK) break;
    end
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rises = rise_cnt - r0;
    fvs   = fv_cnt - f0;
  endtask

  initial begin
    int lw;
    int r;
    int f;
    int r0;
    int l0;

    // Power-up reset.
    #1 reset_n = 1'b0;
    #22;
    check("rst_load", JOY_LOAD, 1);
    check("rst_clk", JOY_CLK, 0);
    check("rst_j1", joystick1, 0);
    check("rst_j2", joystick2, 0);
    check("rst_fv", frame_valid, 0);

    // Start a frame and reset it in the middle of SHIFT while JOY_CLK is high.
    chain_pat = 32'h1234_5678;
    ena = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (!JOY_LOAD) break;
    end
    r0 = rise_cnt;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (rise_cnt - r0 >= 10 && JOY_CLK) break;
    end
    check("mid_shift_clk_high", JOY_CLK, 1);
    #1 reset_n = 1'b0;
    #1;
    check("mrst_clk", JOY_CLK, 0);
    check("mrst_load", JOY_LOAD, 1);
    check("mrst_j1", joystick1, 0);
    check("mrst_j2", joystick2, 0);
    check("mrst_fv", frame_valid, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // First frame after reset: LOAD is GAP_TICKS ticks after release. The frame
    // differs from the reset prev_raw, so nothing is published.
    run_frame(32'hFFFE_FFFB, -1, lw, r, f);
    check("rel_load_wait", lw, GAP_TICKS * CLK_DIV);
    check("f1_rises", r, 32);
    check("f1_fv", f, 0);
    check("f1_j1", joystick1, 16'h0000);
    check("f1_j2", joystick2, 16'h0000);

    // A second identical frame publishes.
    run_frame(32'hFFFE_FFFB, -1, lw, r, f);
    check("f2_rises", r, 32);
    check("f2_fv", f, 1);
    check("f2_j1", joystick1, 16'h0004);
    check("f2_j2", joystick2, 16'h0001);
    check("f2_fv_j1", fv_j1, 16'h0004);
    check("f2_fv_j2", fv_j2, 16'h0001);

    // Pin timing.
    check("load_len", last_load_len, CLK_DIV);
    check("clk_spacing_bad", spacing_bad, 0);
    check("clk_edge_in_load", edge_in_load, 0);

    // Glitch filter.
    run_frame(32'hFFFF_FFFE, -1, lw, r, f);
    check("g0_fv", f, 0);
    check("g0_j1", joystick1, 16'h0004);
    run_frame(32'hFFFF_FFFE, -1, lw, r, f);
    check("gN_fv", f, 1);
    check("gN_j1", joystick1, 16'h0001);
    check("gN_j2", joystick2, 16'h0000);
    run_frame(32'hFFFF_FFFF, -1, lw, r, f);
    check("gN1_fv", f, 0);
    check("gN1_j1", joystick1, 16'h0001);
    run_frame(32'hFFFF_FFFF, -1, lw, r, f);
    check("gN2_fv", f, 1);
    check("gN2_j1", joystick1, 16'h0000);
    check("gN2_fv_j1", fv_j1, 16'h0000);

    // Drop ena during SHIFT: the frame completes and publishes, then idle clears.
    run_frame(32'hA5A5_5A5A, -1, lw, r, f);
    check("e0_fv", f, 0);
    run_frame(32'hA5A5_5A5A, 5, lw, r, f);
    check("e1_rises", r, 32);
    check("e1_fv", f, 1);
    check("e1_fv_j1", fv_j1, 16'hA5A5);
    check("e1_fv_j2", fv_j2, 16'h5A5A);
    check("e1_j1_cleared", joystick1, 16'h0000);
    check("e1_j2_cleared", joystick2, 16'h0000);
    l0 = load_cnt;
    repeat (100) @(posedge clk);
    #1;
    check("ena0_no_load", load_cnt - l0, 0);
    check("ena0_load_pin", JOY_LOAD, 1);

    // Disconnected adapter: the first frame differs from the last raw value,
    // and the next two publish all-zero words.
    disc = 1'b1;
    ena = 1'b1;
    run_frame(32'h0000_0000, -1, lw, r, f);
    check("d1_fv", f, 0);
    check("d1_j1", joystick1, 16'h0000);
    run_frame(32'h0000_0000, -1, lw, r, f);
    check("d2_fv", f, 1);
    check("d2_j1", joystick1, 16'h0000);
    check("d2_j2", joystick2, 16'h0000);
    run_frame(32'h0000_0000, -1, lw, r, f);
    check("d3_fv", f, 1);
    check("d3_rises", r, 32);
    check("d3_j2", joystick2, 16'h0000);

    check("end_spacing_bad", spacing_bad, 0);
    check("end_edge_in_load", edge_in_load, 0);
    check("end_load_len", last_load_len, CLK_DIV);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
